mem_slot_scheduler: RTL and testbench
=====================================

# mem_slot_scheduler

Time-slot scheduler for the shared RAM/ROM port. It divides memory bandwidth into a fixed four-slot rotation and grants each slot to the CPU, the video fetcher, or one of the shared requesters: sound, internal floppy, or external floppy. It drives the memory address and strobes, and it produces `cpuBusControl` for the data controller. It also returns one-cycle acknowledges so requesters can latch `memoryDataIn`.

## Interface
Parameters:
- `AW`, 22: memory address width.

Ports:
- `clk` in 1: system clock.
- `_reset` in 1: asynchronous, active-low reset.
- `cep` in 1: clock enable. All state advances only on `clk` edges where `cep`=1.
- `cpuReq` in 1: CPU wants a bus cycle (level).
- `cpuWe` in 1: CPU cycle is a write.
- `cpuAddr` in AW: CPU address.
- `videoReq` in 1: video fetch pending (level, low during blanking).
- `videoAddr` in AW: video fetch address.
- `sndReq` in 1: sound sample fetch pending (level).
- `sndAddr` in AW: sound buffer address.
- `dskReqInt` / `dskReqExt` in 1: floppy read pending for the internal / external drive.
- `dskAddrInt` / `dskAddrExt` in AW: floppy read addresses.
- `cpuBusControl` out 1: the current slot is owned by the CPU.
- `cpuAck`, `videoAck`, `sndAck`, `dskAckInt`, `dskAckExt` out 1: one-clk completion pulses.
- `memAddr` out AW: registered memory address.
- `memOE` out 1: read strobe.
- `memWE` out 1: write strobe.

## Operation
- Phase counter `phase[2:0]` increments on every `cep` and wraps from 7 to 0.
- Slot = `phase[2:1]`, two `cep` ticks long.
  - `phase[0]`=0 is the slot-start tick.
  - `phase[0]`=1 is the slot-end tick.
- Slot types: 0 = CPU, 1 = VIDEO, 2 = CPU, 3 = SHARED.
- Owner is decided at the slot-start tick from request levels sampled on that edge:
  - CPU slot: owner is CPU if `cpuReq`, else NONE. A CPU slot is never given to another requester.
  - VIDEO slot: owner is VIDEO if `videoReq`, else the slot is handled as a SHARED slot.
  - SHARED slot: priority is SND > DISK > NONE.
    - DISK chooses between INT and EXT round-robin using the `lastDisk` bit.
    - With both disks requesting, the disk not served last wins.
    - With one disk requesting, that disk wins.
    - `lastDisk` updates only when a disk is granted.
- At slot start, registered on the same edge:
  - `memAddr` is set to the owner's address (unchanged if NONE).
  - `memOE` is set to (owner≠NONE and not CPU-write).
  - `memWE` is set to (owner=CPU and `cpuWe`).
  - `cpuBusControl` is set to (owner=CPU).
- At slot end, the owner's ack is asserted.
  - The ack is high for exactly the one `clk` cycle following the slot-end edge.
  - `memOE`, `memWE` and `cpuBusControl` clear on that edge.
  - `memAddr` holds its value.
- A request deasserted after grant does not abort the access. The ack is still issued.
- A request deasserted before the slot-start edge is not granted.
- Only one ack is ever high in a given cycle.
- Requests stay asserted until acked. Each ack consumes exactly one access.

## Timing
- Reset (async assert, sync release):
  - `phase`=0, owner=NONE, `lastDisk`=EXT (so INT wins the first tie).
  - All outputs are 0; `memAddr`=0.
- Reset asserted mid-slot: the access is abandoned, no ack is produced, and outputs go to 0 immediately.
- Latency from slot-start `cep` edge to ack pulse = one `cep` period plus one clk.
- With `cep` every clk, a granted access is acked 2 clks after the slot-start edge.
- Throughput per 8-`cep` rotation:
  - CPU: 2 accesses.
  - Video: 1 access.
  - Shared: 1 access, plus 1 more when video is idle.
- Sound worst-case wait is 8 `cep` ticks. Disk worst-case wait is bounded only by sound holding its request.
- `cep`=0 freezes all state. An ack that is already high still drops after one clk.

## Test plan
- **Reset.** Pulse `_reset` low mid-slot with `cpuReq`=1.
  - All outputs 0 immediately.
  - After release, the first CPU grant happens at `phase`=0 and `cpuAck` follows at `phase`=2.
- **CPU write.** `cpuReq`=1, `cpuWe`=1, `cpuAddr`=22'h012345, `cep` continuous.
  - `memWE`=1 and `memAddr`=22'h012345 for slots 0 and 2.
  - `cpuAck` pulses twice per 8 cycles.
  - `memWE` is never asserted in slots 1 or 3.
- **Video idle.** `videoReq`=0, `sndReq`=1, `dskReqInt`=1.
  - Slot 1 grants sound; slot 3 grants internal disk.
  - `sndAck` precedes `dskAckInt` by 4 `cep` ticks.
- **Disk round-robin.** Both disk requests held, sound and video idle.
  - Grants alternate INT, EXT, INT, EXT.
  - First grant is INT.
- **Drop after grant.** Deassert `sndReq` on the clk after the slot-start edge.
  - `sndAck` is still issued.
  - No second grant occurs.
- **`cep` gating.** Hold `cep` low for 5 clks mid-slot.
  - `phase`, `memAddr` and strobes are frozen.
  - The ack appears only after the next `cep` edge.

Source files
------------

// File: rtl/mem_slot_scheduler_if.sv
// Request/acknowledge and memory-port signals shared by the slot scheduler and its clients.
// The scheduler connects through the slave modport and the requesters through master.
interface mem_slot_scheduler_if #(
   parameter int AW = 22
);
   logic          cpuReq;
   logic          cpuWe;
   logic [AW-1:0] cpuAddr;
   logic          videoReq;
   logic [AW-1:0] videoAddr;
   logic          sndReq;
   logic [AW-1:0] sndAddr;
   logic          dskReqInt;
   logic          dskReqExt;
   logic [AW-1:0] dskAddrInt;
   logic [AW-1:0] dskAddrExt;

   logic          cpuBusControl;
   logic          cpuAck;
   logic          videoAck;
   logic          sndAck;
   logic          dskAckInt;
   logic          dskAckExt;
   logic [AW-1:0] memAddr;
   logic          memOE;
   logic          memWE;

   modport master (
      output cpuReq, cpuWe, cpuAddr, videoReq, videoAddr, sndReq, sndAddr,
             dskReqInt, dskReqExt, dskAddrInt, dskAddrExt,
      input  cpuBusControl, cpuAck, videoAck, sndAck, dskAckInt, dskAckExt,
             memAddr, memOE, memWE
   );

   modport slave (
      input  cpuReq, cpuWe, cpuAddr, videoReq, videoAddr, sndReq, sndAddr,
             dskReqInt, dskReqExt, dskAddrInt, dskAddrExt,
      output cpuBusControl, cpuAck, videoAck, sndAck, dskAckInt, dskAckExt,
             memAddr, memOE, memWE
   );
endinterface

// File: rtl/mem_slot_scheduler.sv
// Four-slot rotation (CPU, VIDEO, CPU, SHARED) over the shared memory port, two cep ticks per slot.
// The owner is latched at the slot-start tick and acknowledged at the slot-end tick.
module mem_slot_scheduler #(
   parameter int AW = 22
) (
   input  logic                 clk,
   input  logic                 _reset,
   input  logic                 cep,
   mem_slot_scheduler_if.slave  bus
);
   typedef enum logic [2:0] {
      OWN_NONE    = 3'd0,
      OWN_CPU     = 3'd1,
      OWN_VIDEO   = 3'd2,
      OWN_SND     = 3'd3,
      OWN_DSK_INT = 3'd4,
      OWN_DSK_EXT = 3'd5
   } owner_t;

   logic [2:0]    phaseReg, phaseNext;
   owner_t        ownerReg, ownerNext;
   owner_t        grant, diskPick;
   logic          lastDiskReg, lastDiskNext;   // 1 = external drive served last
   logic [AW-1:0] memAddrReg, memAddrNext, grantAddr;
   logic          memOEReg, memOENext;
   logic          memWEReg, memWENext;
   logic          busCtlReg, busCtlNext;
   logic [4:0]    ackReg, ackNext, ownerHit;
   logic          grantWrite;

   // Slot arbitration from the request levels present at the slot-start edge.
   always_comb begin
      diskPick = OWN_NONE;
      if (bus.dskReqInt && (!bus.dskReqExt || lastDiskReg)) begin
         diskPick = OWN_DSK_INT;
      end else if (bus.dskReqExt) begin
         diskPick = OWN_DSK_EXT;
      end

      grant = OWN_NONE;
      case (phaseReg[2:1])
         2'd0, 2'd2: grant = bus.cpuReq ? OWN_CPU : OWN_NONE;
         2'd1:       grant = bus.videoReq ? OWN_VIDEO : (bus.sndReq ? OWN_SND : diskPick);
         default:    grant = bus.sndReq ? OWN_SND : diskPick;
      endcase
   end

   always_comb begin
      grantAddr = memAddrReg;
      case (grant)
         OWN_CPU:     grantAddr = bus.cpuAddr;
         OWN_VIDEO:   grantAddr = bus.videoAddr;
         OWN_SND:     grantAddr = bus.sndAddr;
         OWN_DSK_INT: grantAddr = bus.dskAddrInt;
         OWN_DSK_EXT: grantAddr = bus.dskAddrExt;
         default:     grantAddr = memAddrReg;
      endcase
   end

   assign grantWrite = (grant == OWN_CPU) && bus.cpuWe;

   // ownerHit bit gi is the ack line of owner code gi+1.
   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_ackMap
         assign ownerHit[gi] = (ownerReg == owner_t'(3'(gi + 1)));
      end
   endgenerate

   always_comb begin
      phaseNext    = phaseReg;
      ownerNext    = ownerReg;
      lastDiskNext = lastDiskReg;
      memAddrNext  = memAddrReg;
      memOENext    = memOEReg;
      memWENext    = memWEReg;
      busCtlNext   = busCtlReg;
      ackNext      = '0;

      if (cep) begin
         phaseNext = phaseReg + 3'd1;
         if (!phaseReg[0]) begin
            ownerNext   = grant;
            memAddrNext = grantAddr;
            memOENext   = (grant != OWN_NONE) && !grantWrite;
            memWENext   = grantWrite;
            busCtlNext  = (grant == OWN_CPU);
            if (grant == OWN_DSK_INT) begin
               lastDiskNext = 1'b0;
            end else if (grant == OWN_DSK_EXT) begin
               lastDiskNext = 1'b1;
            end
         end else begin
            ackNext    = ownerHit;
            ownerNext  = OWN_NONE;
            memOENext  = 1'b0;
            memWENext  = 1'b0;
            busCtlNext = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         phaseReg    <= 3'd0;
         ownerReg    <= OWN_NONE;
         lastDiskReg <= 1'b1;
         memAddrReg  <= '0;
         memOEReg    <= 1'b0;
         memWEReg    <= 1'b0;
         busCtlReg   <= 1'b0;
         ackReg      <= '0;
      end else begin
         phaseReg    <= phaseNext;
         ownerReg    <= ownerNext;
         lastDiskReg <= lastDiskNext;
         memAddrReg  <= memAddrNext;
         memOEReg    <= memOENext;
         memWEReg    <= memWENext;
         busCtlReg   <= busCtlNext;
         ackReg      <= ackNext;
      end
   end

   assign bus.memAddr       = memAddrReg;
   assign bus.memOE         = memOEReg;
   assign bus.memWE         = memWEReg;
   assign bus.cpuBusControl = busCtlReg;
   assign bus.cpuAck        = ackReg[0];
   assign bus.videoAck      = ackReg[1];
   assign bus.sndAck        = ackReg[2];
   assign bus.dskAckInt     = ackReg[3];
   assign bus.dskAckExt     = ackReg[4];
endmodule

// File: tb/tb_mem_slot_scheduler.sv
// Bench for mem_slot_scheduler: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a slot-level behavioural model.
module tb_mem_slot_scheduler;
   localparam int AW = 22;

   typedef enum int {W_NONE = 0, W_CPU = 1, W_VID = 2, W_SND = 3, W_DI = 4, W_DE = 5} who_t;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   logic cep  = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit checkOn = 1'b0;

   mem_slot_scheduler_if #(.AW(AW)) bus ();

   mem_slot_scheduler #(.AW(AW)) dut (
      .clk    (clk),
      ._reset (rstN),
      .cep    (cep),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned   ticks    = 0;      // cep ticks since reset
   bit            accValid = 1'b0;   // an access is in flight in the current slot
   who_t          accWho   = W_NONE;
   bit            accWrite = 1'b0;
   bit            intLast  = 1'b0;   // internal drive was the last disk served
   logic [AW-1:0] expAddr  = '0;
   who_t          expAck   = W_NONE;
   who_t          modelWho = W_NONE;

   function automatic who_t pickShared();
      if (bus.sndReq) return W_SND;
      if (bus.dskReqInt && bus.dskReqExt) return intLast ? W_DE : W_DI;
      if (bus.dskReqInt) return W_DI;
      if (bus.dskReqExt) return W_DE;
      return W_NONE;
   endfunction

   function automatic who_t pickOwner(input int unsigned slot);
      if (slot == 0 || slot == 2) return bus.cpuReq ? W_CPU : W_NONE;
      if (slot == 1 && bus.videoReq) return W_VID;
      return pickShared();
   endfunction

   function automatic logic [AW-1:0] addrOf(input who_t w);
      if (w == W_CPU) return bus.cpuAddr;
      if (w == W_VID) return bus.videoAddr;
      if (w == W_SND) return bus.sndAddr;
      if (w == W_DI)  return bus.dskAddrInt;
      return bus.dskAddrExt;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rstN);
         if (!rstN) begin
            ticks    = 0;
            accValid = 1'b0;
            accWho   = W_NONE;
            accWrite = 1'b0;
            intLast  = 1'b0;
            expAddr  = '0;
            expAck   = W_NONE;
         end else begin
            expAck = W_NONE;
            if (cep) begin
               if (ticks % 2 == 0) begin
                  modelWho = pickOwner((ticks / 2) % 4);
                  if (modelWho != W_NONE) begin
                     accValid = 1'b1;
                     accWho   = modelWho;
                     accWrite = (modelWho == W_CPU) && bus.cpuWe;
                     expAddr  = addrOf(modelWho);
                     if (modelWho == W_DI) intLast = 1'b1;
                     if (modelWho == W_DE) intLast = 1'b0;
                  end
               end else begin
                  if (accValid) expAck = accWho;
                  accValid = 1'b0;
               end
               ticks++;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [4:0] ackVec, expVec;

   initial begin
      forever begin
         @(negedge clk);
         if (checkOn) begin
            cyc++;
            ackVec = {bus.dskAckExt, bus.dskAckInt, bus.sndAck, bus.videoAck, bus.cpuAck};
            expVec = (expAck == W_NONE) ? 5'b0 : 5'(1 << (int'(expAck) - 1));
            check("memAddr", 32'(bus.memAddr), 32'(expAddr));
            check("memOE", 32'(bus.memOE), 32'(accValid && !accWrite));
            check("memWE", 32'(bus.memWE), 32'(accValid && accWrite));
            check("cpuBusControl", 32'(bus.cpuBusControl), 32'(accValid && accWho == W_CPU));
            check("ack vector", 32'(ackVec), 32'(expVec));
            if (ackVec != 5'b0)
               $display("cyc %0d ack=%b memAddr=%h", cyc, ackVec, bus.memAddr);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idleInputs();
      bus.cpuReq     = 1'b0;
      bus.cpuWe      = 1'b0;
      bus.cpuAddr    = '0;
      bus.videoReq   = 1'b0;
      bus.videoAddr  = 22'h100000;
      bus.sndReq     = 1'b0;
      bus.sndAddr    = 22'h200000;
      bus.dskReqInt  = 1'b0;
      bus.dskReqExt  = 1'b0;
      bus.dskAddrInt = 22'h300000;
      bus.dskAddrExt = 22'h380000;
   endtask

   // Called just after a falling edge; releases reset on a falling edge.
   task automatic restart();
      #2 rstN = 1'b0;
      repeat (2) @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic checkAllZero(input string name);
      check({name, " addr"}, 32'(bus.memAddr), 32'd0);
      check({name, " strobes/acks"}, 32'({bus.memOE, bus.memWE, bus.cpuBusControl, bus.cpuAck,
            bus.videoAck, bus.sndAck, bus.dskAckInt, bus.dskAckExt}), 32'd0);
   endtask

   function automatic bit nextReq(input bit cur, input bit acked);
      if (acked) return $urandom_range(0, 1) == 1;
      if (!cur)  return $urandom_range(0, 2) == 0;
      return cur;
   endfunction

   task automatic agentStep();
      bit upd;
      upd = (expAck == W_CPU) || !bus.cpuReq;
      bus.cpuReq = nextReq(bus.cpuReq, expAck == W_CPU);
      if (upd) begin
         bus.cpuWe   = 1'($urandom_range(0, 1));
         bus.cpuAddr = AW'($urandom);
      end
      upd = (expAck == W_VID) || !bus.videoReq;
      bus.videoReq = nextReq(bus.videoReq, expAck == W_VID);
      if (upd) bus.videoAddr = AW'($urandom);
      upd = (expAck == W_SND) || !bus.sndReq;
      bus.sndReq = nextReq(bus.sndReq, expAck == W_SND);
      if (upd) bus.sndAddr = AW'($urandom);
      upd = (expAck == W_DI) || !bus.dskReqInt;
      bus.dskReqInt = nextReq(bus.dskReqInt, expAck == W_DI);
      if (upd) bus.dskAddrInt = AW'($urandom);
      upd = (expAck == W_DE) || !bus.dskReqExt;
      bus.dskReqExt = nextReq(bus.dskReqExt, expAck == W_DE);
      if (upd) bus.dskAddrExt = AW'($urandom);
   endtask

   // ---------------- scenarios ----------------
   int weCnt, badWe, ackCnt, firstAck, modelAcks, sndAt, dskAt, mSndAt, mDskAt, sndCnt;
   int nDisk, nModel;
   int diskSeq[4];
   int modelSeq[4];

   initial begin
      idleInputs();
      repeat (3) @(negedge clk);
      checkOn = 1'b1;
      checkAllZero("held reset");

      // CPU write stream.
      bus.cpuReq = 1'b1; bus.cpuWe = 1'b1; bus.cpuAddr = 22'h012345; cep = 1'b1;
      restart();
      weCnt = 0; badWe = 0; ackCnt = 0; firstAck = 0; modelAcks = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (bus.memWE) begin
            weCnt++;
            if (i % 8 != 1 && i % 8 != 5) badWe++;
            check("write addr", 32'(bus.memAddr), 32'h012345);
         end
         if (bus.cpuAck) begin
            ackCnt++;
            if (firstAck == 0) firstAck = i;
         end
         if (expAck == W_CPU) modelAcks++;
      end
      check("write strobe count", 32'(weCnt), 32'd4);
      check("write outside cpu slot", 32'(badWe), 32'd0);
      check("cpuAck count", 32'(ackCnt), 32'd4);
      check("first cpuAck at phase 2", 32'(firstAck), 32'd2);
      check("model cpu acks", 32'(modelAcks), 32'd4);

      // Reset asserted mid-slot abandons the access.
      @(negedge clk);
      check("write in flight", 32'(bus.memWE), 32'd1);
      #2 rstN = 1'b0;
      #1 checkAllZero("async reset");
      @(negedge clk);
      rstN = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         if (i == 1) begin
            check("regrant after reset", 32'(bus.memWE), 32'd1);
            check("abandoned access not acked", 32'(bus.cpuAck), 32'd0);
         end else begin
            check("cpuAck after reset", 32'(bus.cpuAck), 32'd1);
         end
      end

      // Video idle: sound takes slot 1, internal disk slot 3.
      @(negedge clk);
      idleInputs();
      bus.sndReq = 1'b1; bus.dskReqInt = 1'b1;
      restart();
      sndAt = 0; dskAt = 0; mSndAt = 0; mDskAt = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (bus.sndAck && sndAt == 0) sndAt = i;
         if (bus.dskAckInt && dskAt == 0) dskAt = i;
         if (expAck == W_SND) begin mSndAt = i; bus.sndReq = 1'b0; end
         if (expAck == W_DI) begin mDskAt = i; bus.dskReqInt = 1'b0; end
      end
      check("sndAck time", 32'(sndAt), 32'd4);
      check("dskAckInt time", 32'(dskAt), 32'd8);
      check("snd to disk spacing", 32'(dskAt - sndAt), 32'd4);
      check("model snd time", 32'(mSndAt), 32'd4);
      check("model disk time", 32'(mDskAt), 32'd8);

      // Disk round-robin with both drives requesting.
      @(negedge clk);
      idleInputs();
      bus.dskReqInt = 1'b1; bus.dskReqExt = 1'b1;
      restart();
      nDisk = 0; nModel = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if ((bus.dskAckInt || bus.dskAckExt) && nDisk < 4) begin
            diskSeq[nDisk] = bus.dskAckInt ? 1 : 2;
            nDisk++;
         end
         if ((expAck == W_DI || expAck == W_DE) && nModel < 4) begin
            modelSeq[nModel] = (expAck == W_DI) ? 1 : 2;
            nModel++;
         end
      end
      check("disk grant count", 32'(nDisk), 32'd4);
      check("model disk grant count", 32'(nModel), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < nDisk) check("disk alternation", 32'(diskSeq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
         if (k < nModel) check("model disk alternation", 32'(modelSeq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      end

      // Sound request dropped right after its grant.
      @(negedge clk);
      idleInputs();
      bus.videoReq = 1'b1; bus.sndReq = 1'b1;
      restart();
      sndAt = 0; sndCnt = 0; modelAcks = 0;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if (bus.sndAck) begin
            sndCnt++;
            if (sndAt == 0) sndAt = i;
         end
         if (expAck == W_SND) modelAcks++;
         if (i == 7) bus.sndReq = 1'b0;
      end
      check("dropped snd ack time", 32'(sndAt), 32'd8);
      check("dropped snd ack count", 32'(sndCnt), 32'd1);
      check("model dropped snd acks", 32'(modelAcks), 32'd1);

      // cep held low for five clocks in the middle of a CPU read slot.
      @(negedge clk);
      idleInputs();
      bus.cpuReq = 1'b1; bus.cpuAddr = 22'h2abcde;
      restart();
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i >= 2 && i <= 6) begin
            check("gated memOE", 32'(bus.memOE), 32'd1);
            check("gated memAddr", 32'(bus.memAddr), 32'h2abcde);
            check("gated cpuAck", 32'(bus.cpuAck), 32'd0);
         end
         if (i == 7) begin
            check("ack after gate", 32'(bus.cpuAck), 32'd1);
            check("memOE cleared at slot end", 32'(bus.memOE), 32'd0);
         end
         if (i == 8) check("ack drops while gated", 32'(bus.cpuAck), 32'd0);
         if (i == 1 || i == 7) cep = 1'b0;
         if (i == 6 || i == 9) cep = 1'b1;
      end

      // Randomized traffic with a random cep pattern and one async reset.
      @(negedge clk);
      idleInputs();
      restart();
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (i == 700) begin
            #2 rstN = 1'b0;
            #1 checkAllZero("random async reset");
            @(negedge clk);
            rstN = 1'b1;
         end
         cep = ($urandom_range(0, 3) != 0);
         agentStep();
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
